sseg_scan_driver: RTL

//  Downstream display stage: takes the 32-bit value the stack/queue core drives on toSSEG and

---
 rtl/sseg_pkg.sv | 16 +
 rtl/hex_to_sseg.sv | 14 +
 rtl/sseg_scan_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the 7-segment scan driver: segment encodings and index widths.
package sseg_pkg;

    // Width of the digit index; covers up to 8 scanned digits.
    localparam int unsigned DIG_W = $clog2(8);

    // All segments off (active low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Table lookup; every nibble value has an entry.
    always_comb begin
        seg_o = SEG_HEX[hex_i];
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed driver for a common-anode 8-digit 7-segment display.
// A shadow copy of value_in/dp_in is taken once per scan frame so a frame never tears.
// Optional build macro SSEG_LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero nibble (digit 0 always shown).
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned NUM_DIGITS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value_in,
    input  logic [7:0]  dp_in,
    input  logic        disp_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]    PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_MAX   = DIG_W'(NUM_DIGITS - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [DIG_W-1:0] digit_q, digit_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [7:0]       dp_sh_q, dp_sh_d;
    logic             first_q, first_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_tick_q, frame_tick_d;

    logic             slot_tick;
    logic             load;
    logic [3:0]       nibble;
    logic [6:0]       hex_seg;
    logic             lz_blank;

    // Prescaler, digit counter and once-per-frame shadow load.
    always_comb begin
        slot_tick = (presc_q == PRESC_MAX);
        // first_q forces a load on the first slot so the display is not stale zeros for a frame.
        load      = slot_tick && ((digit_q == DIG_MAX) || first_q);
        presc_d   = slot_tick ? '0 : presc_q + 1'b1;
        digit_d   = digit_q;
        first_d   = first_q;
        shadow_d  = shadow_q;
        dp_sh_d   = dp_sh_q;
        if (slot_tick) begin
            digit_d = (digit_q == DIG_MAX) ? '0 : digit_q + 1'b1;
            first_d = 1'b0;
        end
        if (load) begin
            shadow_d = value_in;
            dp_sh_d  = dp_in;
        end
    end

    assign nibble = shadow_q[{digit_q, 2'b00} +: 4];

    hex_to_sseg u_hex_to_sseg (
        .hex_i (nibble),
        .seg_o (hex_seg)
    );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // Blank when this nibble and everything above it are zero; digit 0 always shows.
    assign lz_blank = (digit_q != '0) && ((shadow_q >> {digit_q, 2'b00}) == 32'h0);
`else
    assign lz_blank = 1'b0;
`endif

    // Next values for the registered display outputs.
    always_comb begin
        an_d         = 8'hFF;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        frame_tick_d = load;
        if (disp_en) begin
            an_d  = ~(8'b1 << digit_q);
            seg_d = lz_blank ? SEG_BLANK : hex_seg;
            dp_d  = ~dp_sh_q[digit_q];
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q      <= '0;
            digit_q      <= '0;
            shadow_q     <= '0;
            dp_sh_q      <= '0;
            first_q      <= 1'b1;
            an_q         <= 8'hFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            shadow_q     <= shadow_d;
            dp_sh_q      <= dp_sh_d;
            first_q      <= first_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule
